// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: word width, reset defaults,
// FSM state encodings, IF/ID register controls and counter increment helpers.
package fetch_stage_pkg;

    localparam int WORD_W = 16;

    localparam logic [WORD_W-1:0] DEFAULT_RESET_PC = 16'h0000;
    localparam logic [WORD_W-1:0] DEFAULT_NOP_WORD = 16'hB000;

    typedef enum logic [1:0] {
        ST_FETCH = 2'b00,
        ST_MISS  = 2'b01,
        ST_FLUSH = 2'b10
    } fetch_state_e;

    typedef enum logic [1:0] {
        IFID_HOLD   = 2'b00,
        IFID_LOAD   = 2'b01,
        IFID_SQUASH = 2'b10
    } ifid_ctrl_e;

    function automatic logic [WORD_W-1:0] wrap_inc(input logic [WORD_W-1:0] value);
        return value + {{(WORD_W-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [WORD_W-1:0] sat_inc(input logic [WORD_W-1:0] value);
        logic [WORD_W-1:0] result;
        if (value == {WORD_W{1'b1}}) begin
            result = value;
        end else begin
            result = value + {{(WORD_W-1){1'b0}}, 1'b1};
        end
        return result;
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage to instruction-cache connection: address/read/flush out, hit/data back.
interface fetch_stage_if;
    import fetch_stage_pkg::*;

    logic [WORD_W-1:0] c_address;
    logic              c_read;
    logic              c_flush;
    logic              c_hit;
    logic [WORD_W-1:0] c_data;

    modport master (
        output c_address,
        output c_read,
        output c_flush,
        input  c_hit,
        input  c_data
    );

    modport slave (
        input  c_address,
        input  c_read,
        input  c_flush,
        output c_hit,
        output c_data
    );

endinterface

// File: rtl/fetch_stage_if_id_register.sv
// IF/ID pipeline register: holds the delivered instruction word, its PC and a valid bit.
module fetch_stage_if_id_register
    import fetch_stage_pkg::*;
#(
    parameter logic [WORD_W-1:0] NOP_WORD = DEFAULT_NOP_WORD
) (
    input  logic              clk,
    input  logic              reset_n,
    input  ifid_ctrl_e        ctrl,
    input  logic [WORD_W-1:0] d_instruction,
    input  logic [WORD_W-1:0] d_pc,
    output logic [WORD_W-1:0] o_instruction,
    output logic [WORD_W-1:0] o_pc,
    output logic              o_valid
);

    logic [WORD_W-1:0] instr_r;
    logic [WORD_W-1:0] pc_r;
    logic              valid_r;

    // Load a fetched word, squash to a NOP bubble (PC kept), or hold for back-pressure
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            instr_r <= NOP_WORD;
            pc_r    <= {WORD_W{1'b0}};
            valid_r <= 1'b0;
        end else begin
            case (ctrl)
                IFID_LOAD: begin
                    instr_r <= d_instruction;
                    pc_r    <= d_pc;
                    valid_r <= 1'b1;
                end
                IFID_SQUASH: begin
                    instr_r <= NOP_WORD;
                    pc_r    <= pc_r;
                    valid_r <= 1'b0;
                end
                IFID_HOLD: begin
                    instr_r <= instr_r;
                    pc_r    <= pc_r;
                    valid_r <= valid_r;
                end
                default: begin
                    instr_r <= instr_r;
                    pc_r    <= pc_r;
                    valid_r <= valid_r;
                end
            endcase
        end
    end

    assign o_instruction = instr_r;
    assign o_pc          = pc_r;
    assign o_valid       = valid_r;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction cache, holds the address
// through miss refills, handles stall/redirect and counts delivered instructions and misses.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC = DEFAULT_RESET_PC,
    parameter logic [WORD_W-1:0] NOP_WORD = DEFAULT_NOP_WORD
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              stall,
    input  logic              redirect,
    input  logic [WORD_W-1:0] redirect_pc,
    fetch_stage_if.master     cache,
    output logic [WORD_W-1:0] instruction_count,
    output logic [WORD_W-1:0] miss_count,
    output logic [WORD_W-1:0] o_instruction,
    output logic [WORD_W-1:0] o_pc,
    output logic              o_valid,
    output logic [1:0]        o_fetch_state
);

    fetch_state_e      state_r;
    fetch_state_e      state_nxt_s;
    logic [WORD_W-1:0] pc_r;
    logic [WORD_W-1:0] pc_nxt_s;
    logic [WORD_W-1:0] icnt_r;
    logic [WORD_W-1:0] mcnt_r;
    logic              c_read_r;
    logic              c_flush_r;
    logic              count_inst_s;
    logic              count_miss_s;
    ifid_ctrl_e        ifid_ctrl_s;

    // Next state, next PC and IF/ID control; redirect outranks stall, stall outranks c_hit
    always_comb begin
        state_nxt_s  = state_r;
        pc_nxt_s     = pc_r;
        ifid_ctrl_s  = IFID_HOLD;
        count_inst_s = 1'b0;
        count_miss_s = 1'b0;
        if (redirect) begin
            state_nxt_s = ST_FLUSH;
            pc_nxt_s    = redirect_pc;
            ifid_ctrl_s = IFID_SQUASH;
        end else begin
            case (state_r)
                ST_FETCH: begin
                    if (stall) begin
                        state_nxt_s = ST_FETCH;
                    end else if (cache.c_hit) begin
                        ifid_ctrl_s  = IFID_LOAD;
                        pc_nxt_s     = wrap_inc(pc_r);
                        count_inst_s = 1'b1;
                    end else begin
                        ifid_ctrl_s  = IFID_SQUASH;
                        state_nxt_s  = ST_MISS;
                        count_miss_s = 1'b1;
                    end
                end
                ST_MISS: begin
                    // A stalled refill completion is dropped; the word is re-read as a hit
                    if (cache.c_hit) begin
                        state_nxt_s = ST_FETCH;
                        if (!stall) begin
                            ifid_ctrl_s  = IFID_LOAD;
                            pc_nxt_s     = wrap_inc(pc_r);
                            count_inst_s = 1'b1;
                        end else begin
                            ifid_ctrl_s = IFID_HOLD;
                        end
                    end else if (!stall) begin
                        ifid_ctrl_s = IFID_SQUASH;
                    end else begin
                        ifid_ctrl_s = IFID_HOLD;
                    end
                end
                ST_FLUSH: begin
                    state_nxt_s = ST_FETCH;
                end
                default: begin
                    state_nxt_s = ST_FETCH;
                end
            endcase
        end
    end

    // FSM state, PC and registered cache read/flush strobes
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= ST_FETCH;
            pc_r      <= RESET_PC;
            c_read_r  <= 1'b1;
            c_flush_r <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            pc_r      <= pc_nxt_s;
            c_read_r  <= (state_nxt_s != ST_FLUSH);
            c_flush_r <= (state_nxt_s == ST_FLUSH);
        end
    end

    // Delivered-instruction counter wraps (cache LRU timestamp); miss counter saturates
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            icnt_r <= {WORD_W{1'b0}};
            mcnt_r <= {WORD_W{1'b0}};
        end else begin
            icnt_r <= count_inst_s ? wrap_inc(icnt_r) : icnt_r;
            mcnt_r <= count_miss_s ? sat_inc(mcnt_r) : mcnt_r;
        end
    end

    fetch_stage_if_id_register #(
        .NOP_WORD (NOP_WORD)
    ) u_if_id (
        .clk           (clk),
        .reset_n       (reset_n),
        .ctrl          (ifid_ctrl_s),
        .d_instruction (cache.c_data),
        .d_pc          (pc_r),
        .o_instruction (o_instruction),
        .o_pc          (o_pc),
        .o_valid       (o_valid)
    );

    assign cache.c_address   = pc_r;
    assign cache.c_read      = c_read_r;
    assign cache.c_flush     = c_flush_r;
    assign instruction_count = icnt_r;
    assign miss_count        = mcnt_r;
    assign o_fetch_state     = state_r;

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage sitting directly upstream of the 2-way instruction cache: it owns the PC, drives the cache's address/read/flush inputs, and holds the address stable for the full duration of a miss refill. Fetched words land in an IF/ID output register with a valid bit for the decode stage. The block also handles decode back-pressure and branch redirects, and produces the instruction count the cache uses as its LRU timestamp.

## Interface
Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset
- NOP_WORD, 16'hB000, instruction word presented while o_valid=0

Ports:
- clk  in  1  system clock, all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- stall  in  1  decode cannot accept; IF/ID register and PC hold
- redirect  in  1  branch/jump resolved taken; squash and restart at redirect_pc
- redirect_pc  in  16  new fetch address, sampled when redirect=1
- c_hit  in  1  cache hit / refill-complete indication (combinational from cache)
- c_data  in  16  cache read data, valid when c_hit=1
- c_address  out  16  fetch address to cache (= PC register)
- c_read  out  1  fetch request to cache
- c_flush  out  1  abort any cache refill in progress
- instruction_count  out  16  instructions delivered to decode, wraps 16'hFFFF→0
- miss_count  out  16  FETCH→MISS transitions, saturates at 16'hFFFF
- o_instruction  out  16  IF/ID instruction word
- o_pc  out  16  PC of o_instruction
- o_valid  out  1  IF/ID register holds a real instruction
- o_fetch_state  out  2  current FSM state (test visibility)

## Operation
- One clock, clk; asynchronous active-low reset, reset_n. Reset values: PC=RESET_PC, state=FETCH, o_valid=0, o_instruction=NOP_WORD, o_pc=0, c_flush=0, both counters 0.
- Word-addressed PC; sequential next PC = PC+1, 16-bit wrap (16'hFFFF→16'h0000).
- c_address = PC register at all times. c_read = 1 in FETCH and MISS, 0 in FLUSH.
- States (2-bit): FETCH=2'b00, MISS=2'b01, FLUSH=2'b10; 2'b11 unused, returns to FETCH.
- Priority per edge: redirect > stall > c_hit.
- redirect=1 (any state): PC←redirect_pc, o_valid←0, o_instruction←NOP_WORD, c_flush←1, state←FLUSH; fetched word discarded, counters unchanged.
- FLUSH: c_flush=1, c_read=0 for exactly one cycle; next state FETCH, c_flush←0. A fresh redirect in FLUSH reloads PC and stays in FLUSH one more cycle.
- FETCH, stall=1: IF/ID and PC hold; state stays FETCH regardless of c_hit.
- FETCH, stall=0, c_hit=1: o_instruction←c_data, o_pc←PC, o_valid←1, PC←PC+1, instruction_count+1.
- FETCH, stall=0, c_hit=0: o_valid←0 (bubble), state←MISS, miss_count+1 (saturating).
- MISS: PC held, c_read=1. c_hit=1 and stall=0: capture as in FETCH, state←FETCH. c_hit=1 and stall=1: IF/ID holds, state←FETCH (word re-read from cache as a hit next cycle). c_hit=0: stay; stall=0 keeps o_valid=0, stall=1 holds IF/ID.
- No internal timeout: MISS waits indefinitely for c_hit.

## Timing
- Hit: PC presented in cycle N, c_hit same cycle, o_instruction/o_valid visible after edge N; one instruction per cycle at steady state.
- Miss: bubble from edge N; delivery at the edge where c_hit returns (cache refill ≈6 cycles); c_address constant throughout.
- Redirect asserted in cycle N: after edge N c_address=redirect_pc, c_flush=1, c_read=0; after edge N+1 FETCH, c_flush=0; earliest delivery at edge N+2.
- reset_n deassertion mid-miss or mid-flush: all outputs at reset values immediately; first request at RESET_PC on the first clock after release.

## Structure
- Shared package: state encodings, NOP_WORD, WORD_W=16, RESET_PC default.
- One natural sub-module: if_id_register (o_instruction/o_pc/o_valid with load/hold/squash controls). FSM, PC, and counters stay in fetch_stage.

## Test plan
- Reset, cache always hits, c_data=PC^16'h1000 → o_pc 0,1,2,3 on consecutive edges; instruction_count=4 after 4 edges.
- Miss at PC=16'h0008, c_hit returns after 6 cycles with 16'h7A55 → c_address stays 16'h0008 throughout, o_valid=0 during wait, then o_instruction=16'h7A55, o_pc=16'h0008; miss_count=1.
- redirect with redirect_pc=16'h0040 during a MISS → next cycle c_flush=1, c_read=0, c_address=16'h0040; FETCH after one cycle; instruction_count unchanged.
- stall=1 for 3 cycles while hitting → o_instruction/o_pc/PC frozen; stall=1 coincident with redirect → redirect taken, o_valid=0.
- PC=16'hFFFF hit → next c_address=16'h0000; instruction_count preloaded to 16'hFFFF wraps to 0.
- reset_n pulled low in MISS cycle 3 → o_valid=0, state FETCH, c_address=RESET_PC, counters 0.
